// File: rtl/barrett_pkg.sv
// Shared widths, FSM encoding and a ceil(log2) helper for the Barrett
// parameter generator and its reference models.
package barrett_pkg;

  localparam int W  = 64;
  localparam int KW = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLOG = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Smallest k with 2^k >= v; v=0 and v=1 both give 0.
  function automatic logic [KW-1:0] clog2_w(input logic [W-1:0] v);
    logic [W:0]    p;
    logic [KW-1:0] r;
    r = KW'(W);
    for (int i = W; i >= 0; i--) begin
      p = {{W{1'b0}}, 1'b1} << i;
      if (p >= {1'b0, v}) r = KW'(i);
      else                r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/lzc_enc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module lzc_enc #(
  parameter int W  = 64,
  parameter int KW = 7
) (
  input  logic [W-1:0]  a,
  output logic [KW-1:0] zc
);

  // Scan from LSB upward so the highest set bit determines the count.
  always_comb begin
    zc = KW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) zc = KW'(W - 1 - i);
      else      zc = zc;
    end
  end

endmodule

// File: rtl/barrett_param_gen.sv
// Computes k = ceil(log2 q) and mu = floor(2^(2k)/q) for a 64-bit modulus
// using one encode cycle followed by a bit-serial restoring division.
module barrett_param_gen
  import barrett_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  q_out,
  output logic [KW-1:0] k,
  output logic [W:0]    mu,
  output logic          err
);

  state_t        state_r;
  logic [W-1:0]  q_r;
  logic [W-1:0]  rem_r;
  logic [W:0]    quo_r;
  logic [KW:0]   cnt_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [W-1:0]  q_out_r;
  logic [KW-1:0] k_r;
  logic [W:0]    mu_r;
  logic          err_r;

  logic [W-1:0]  qm1_s;
  logic [KW-1:0] lz_s;
  logic [KW-1:0] k_calc_s;
  logic          div_bit_s;
  logic [W:0]    t_s;
  logic [W:0]    diff_s;
  logic          ge_s;
  logic [W-1:0]  rem_nxt_s;
  logic [W:0]    quo_nxt_s;

  assign qm1_s = q_r - {{(W-1){1'b0}}, 1'b1};

  lzc_enc #(.W(W), .KW(KW)) u_lzc (
    .a  (qm1_s),
    .zc (lz_s)
  );

  // Dividend 2^(2k) has its only set bit at the first step, where cnt == 2k.
  always_comb begin
    k_calc_s  = KW'(W) - lz_s;
    div_bit_s = (cnt_r == {k_r, 1'b0});
    t_s       = {rem_r, div_bit_s};
    diff_s    = t_s - {1'b0, q_r};
    ge_s      = (t_s >= {1'b0, q_r});
    if (ge_s) rem_nxt_s = diff_s[W-1:0];
    else      rem_nxt_s = t_s[W-1:0];
    quo_nxt_s = {quo_r[W-1:0], ge_s};
  end

  // Control FSM, division datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      q_r         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      q_out_r     <= '0;
      k_r         <= '0;
      mu_r        <= '0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            q_r        <= q;
            q_out_r    <= q;
            err_r      <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= CLOG;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        CLOG: begin
          rem_r   <= '0;
          quo_r   <= '0;
          state_r <= DIV;
          // A zero modulus still takes one masked step, keeping latency at 2k+2.
          if (q_r == '0) begin
            err_r <= 1'b1;
            k_r   <= '0;
            mu_r  <= '0;
            cnt_r <= '0;
          end else begin
            k_r   <= k_calc_s;
            cnt_r <= {k_calc_s, 1'b0};
          end
        end
        DIV: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          if (cnt_r == '0) begin
            mu_r        <= err_r ? '0 : quo_nxt_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r - {{KW{1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign q_out     = q_out_r;
  assign k         = k_r;
  assign mu        = mu_r;
  assign err       = err_r;

endmodule
